// File: rtl/turn_sequencer.sv
// Purpose : initiator side of the turn handshake; follows the line, debounces nodes, replays a stored list of turn codes.
// Latency : outputs are registered and reflect the state entered on the previous clk_50 edge (node -> start is one cycle after the last debounce sample).
// Backpr. : the executor throttles us through done; we hold start/turn until done or timeout, and input strobes are dropped outside the states that accept them.
//
// Ports: clk_50/rst (sync, active-high); cmd_wr/cmd_data/cmd_clr load and clear the turn list;
//        go starts or replays a run; sensor_l/m/r are the line sensors; done comes from the turn executor;
//        start/turn drive the executor; busy/finished/error report run status; cmd_full/cmd_count/node_count are counters.
module turn_sequencer #(
    parameter int DEPTH        = 16,
    parameter int NODE_DEB     = 4,
    parameter int TURN_TIMEOUT = 50000000
) (
    input  logic                         clk_50,
    input  logic                         rst,
    input  logic                         cmd_wr,
    input  logic [2:0]                   cmd_data,
    input  logic                         cmd_clr,
    input  logic                         go,
    input  logic                         sensor_l,
    input  logic                         sensor_m,
    input  logic                         sensor_r,
    input  logic                         done,
    output logic                         start,
    output logic [2:0]                   turn,
    output logic                         busy,
    output logic                         finished,
    output logic                         error,
    output logic                         cmd_full,
    output logic [$clog2(DEPTH+1)-1:0]   cmd_count,
    output logic [$clog2(DEPTH+1)-1:0]   node_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    // deb only needs to hold 0..NODE_DEB-1: the NODE_DEB-th sample fires the node directly.
    localparam int DW = (NODE_DEB > 1) ? $clog2(NODE_DEB) : 1;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [DW-1:0] DEB_ONE  = DW'(1);
    localparam logic [DW-1:0] DEB_LAST = DW'(NODE_DEB - 1);
    localparam logic [25:0]   TMO_LAST = 26'(TURN_TIMEOUT - 1);

    localparam logic [2:0] T_STOP = 3'b000;
    localparam logic [2:0] T_FWD  = 3'b001;
    localparam logic [2:0] T_MAX  = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FOLLOW,
        S_TURN,
        S_FINISHED,
        S_ERROR
    } state_t;

    state_t          state, state_nxt;
    logic [2:0]      store [DEPTH];
    logic [CW-1:0]   rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]   cmd_count_nxt, node_count_nxt;
    logic [2:0]      cmd, cmd_nxt;
    logic [DW-1:0]   deb, deb_nxt;
    logic            armed, armed_nxt;
    logic [25:0]     timer, timer_nxt;
    logic            wr_en;
    logic            start_nxt, busy_nxt, finished_nxt, error_nxt, cmd_full_nxt;
    logic [2:0]      turn_nxt;
    logic            all_high;
    logic [2:0]      rd_code;

    assign all_high = sensor_l & sensor_m & sensor_r;
    assign rd_code  = store[rd_ptr[AW-1:0]];

    always_comb begin
        state_nxt      = state;
        rd_ptr_nxt     = rd_ptr;
        cmd_nxt        = cmd;
        deb_nxt        = deb;
        armed_nxt      = armed;
        timer_nxt      = timer;
        cmd_count_nxt  = cmd_count;
        node_count_nxt = node_count;
        wr_en          = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_clr) begin
                    cmd_count_nxt  = '0;
                    node_count_nxt = '0;
                end else if (go && (cmd_count != '0)) begin
                    state_nxt      = S_FOLLOW;
                    rd_ptr_nxt     = '0;
                    node_count_nxt = '0;
                    armed_nxt      = 1'b0;
                    deb_nxt        = '0;
                end else if (cmd_wr && !cmd_full && (cmd_data <= T_MAX)) begin
                    wr_en         = 1'b1;
                    cmd_count_nxt = cmd_count + CNT_ONE;
                end
            end
            S_FOLLOW: begin
                if (!all_high) begin
                    // Leaving the line pattern proves we are off the previous node.
                    armed_nxt = 1'b1;
                    deb_nxt   = '0;
                end else if (armed) begin
                    if (deb == DEB_LAST) begin
                        cmd_nxt        = rd_code;
                        node_count_nxt = node_count + CNT_ONE;
                        deb_nxt        = '0;
                        if (rd_code == T_STOP) begin
                            state_nxt = S_FINISHED;
                        end else begin
                            state_nxt = S_TURN;
                            timer_nxt = '0;
                        end
                    end else begin
                        deb_nxt = deb + DEB_ONE;
                    end
                end
            end
            S_TURN: begin
                // done is checked first so it wins over a timeout in the same cycle.
                if (done) begin
                    rd_ptr_nxt = rd_ptr + CNT_ONE;
                    if ((rd_ptr + CNT_ONE) == cmd_count) begin
                        state_nxt = S_FINISHED;
                    end else begin
                        state_nxt = S_FOLLOW;
                        armed_nxt = 1'b0;
                        deb_nxt   = '0;
                    end
                end else if (timer == TMO_LAST) begin
                    state_nxt = S_ERROR;
                end else begin
                    timer_nxt = timer + 26'd1;
                end
            end
            S_FINISHED: begin
                if (cmd_clr) begin
                    state_nxt      = S_IDLE;
                    cmd_count_nxt  = '0;
                    node_count_nxt = '0;
                end else if (go) begin
                    state_nxt      = S_FOLLOW;
                    rd_ptr_nxt     = '0;
                    node_count_nxt = '0;
                    armed_nxt      = 1'b0;
                    deb_nxt        = '0;
                end
            end
            S_ERROR: begin
                if (cmd_clr) begin
                    state_nxt      = S_IDLE;
                    cmd_count_nxt  = '0;
                    node_count_nxt = '0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Outputs decoded from the next state so the registered copies track the state register.
        start_nxt    = (state_nxt == S_TURN);
        busy_nxt     = (state_nxt == S_FOLLOW) || (state_nxt == S_TURN);
        finished_nxt = (state_nxt == S_FINISHED);
        error_nxt    = (state_nxt == S_ERROR);
        cmd_full_nxt = (cmd_count_nxt == CNT_FULL);
        case (state_nxt)
            S_FOLLOW: turn_nxt = T_FWD;
            S_TURN:   turn_nxt = cmd_nxt;
            default:  turn_nxt = T_STOP;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state      <= S_IDLE;
            rd_ptr     <= '0;
            cmd        <= T_STOP;
            deb        <= '0;
            armed      <= 1'b0;
            timer      <= '0;
            cmd_count  <= '0;
            node_count <= '0;
            start      <= 1'b0;
            turn       <= T_STOP;
            busy       <= 1'b0;
            finished   <= 1'b0;
            error      <= 1'b0;
            cmd_full   <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_ptr     <= rd_ptr_nxt;
            cmd        <= cmd_nxt;
            deb        <= deb_nxt;
            armed      <= armed_nxt;
            timer      <= timer_nxt;
            cmd_count  <= cmd_count_nxt;
            node_count <= node_count_nxt;
            start      <= start_nxt;
            turn       <= turn_nxt;
            busy       <= busy_nxt;
            finished   <= finished_nxt;
            error      <= error_nxt;
            cmd_full   <= cmd_full_nxt;
            if (wr_en) begin
                store[cmd_count[AW-1:0]] <= cmd_data;
            end
        end
    end
endmodule

// File: tb/tb_turn_sequencer.sv
// Purpose : directed bench for turn_sequencer with a short turn timeout.
// Latency : inputs change 1 ns after a rising edge; outputs are checked 1 ns after the following edge.
// Backpr. : done is driven by the bench as a one-cycle pulse standing in for the turn executor.
module tb_turn_sequencer;
    logic       clk_50 = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_wr = 1'b0;
    logic [2:0] cmd_data = 3'b000;
    logic       cmd_clr = 1'b0;
    logic       go = 1'b0;
    logic       sensor_l = 1'b0, sensor_m = 1'b0, sensor_r = 1'b0;
    logic       done = 1'b0;
    logic       start, busy, finished, error, cmd_full;
    logic [2:0] turn;
    logic [4:0] cmd_count, node_count;

    int vectors = 0;
    int miscompares = 0;

    turn_sequencer #(.DEPTH(16), .NODE_DEB(4), .TURN_TIMEOUT(100)) dut (
        .clk_50(clk_50), .rst(rst), .cmd_wr(cmd_wr), .cmd_data(cmd_data), .cmd_clr(cmd_clr),
        .go(go), .sensor_l(sensor_l), .sensor_m(sensor_m), .sensor_r(sensor_r), .done(done),
        .start(start), .turn(turn), .busy(busy), .finished(finished), .error(error),
        .cmd_full(cmd_full), .cmd_count(cmd_count), .node_count(node_count)
    );

    always #10 clk_50 = ~clk_50;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_50);
            #1;
        end
    endtask

    task automatic set_sens(input logic [2:0] lmr);
        sensor_l = lmr[2];
        sensor_m = lmr[1];
        sensor_r = lmr[0];
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd_wr = 1'b0; cmd_clr = 1'b0; go = 1'b0; done = 1'b0;
        set_sens(3'b010);
        tick(2);
        rst = 1'b0;
    endtask

    task automatic write_code(input logic [2:0] c);
        cmd_wr = 1'b1; cmd_data = c;
        tick(1);
        cmd_wr = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1; tick(1); go = 1'b0;
    endtask

    task automatic pulse_done();
        done = 1'b1; tick(1); done = 1'b0;
    endtask

    task automatic pulse_clr();
        cmd_clr = 1'b1; tick(1); cmd_clr = 1'b0;
    endtask

    // Leave the line pattern for one sample, then present a node for n samples.
    task automatic approach_node(input int n);
        set_sens(3'b010); tick(1);
        set_sens(3'b111); tick(n);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++; if ({start, busy, finished, error, cmd_full} !== 5'b0) begin
            miscompares++; $display("FAIL reset_flags: got %b expected 00000", {start, busy, finished, error, cmd_full}); end
        vectors++; if (turn !== 3'b000) begin
            miscompares++; $display("FAIL reset_turn: got %b expected 000", turn); end
        vectors++; if (cmd_count !== 5'd0 || node_count !== 5'd0) begin
            miscompares++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", cmd_count, node_count); end
        pulse_go();
        vectors++; if (busy !== 1'b0) begin
            miscompares++; $display("FAIL go_empty_ignored: busy got %b expected 0", busy); end
    endtask

    task automatic test_basic_run();
        do_reset();
        write_code(3'b010); write_code(3'b011); write_code(3'b100);
        vectors++; if (cmd_count !== 5'd3) begin
            miscompares++; $display("FAIL load_count: got %0d expected 3", cmd_count); end
        pulse_go();
        vectors++; if ({busy, start, turn} !== 5'b10001 || node_count !== 5'd0) begin
            miscompares++; $display("FAIL follow_entry: got busy/start/turn %b node %0d expected 10001 node 0", {busy, start, turn}, node_count); end
        set_sens(3'b010); tick(10);
        set_sens(3'b111); tick(3);
        vectors++; if (start !== 1'b0) begin
            miscompares++; $display("FAIL node_early: start got %b expected 0", start); end
        tick(1);
        vectors++; if ({start, turn} !== 4'b1010 || node_count !== 5'd1) begin
            miscompares++; $display("FAIL node1_turn: got start/turn %b node %0d expected 1010 node 1", {start, turn}, node_count); end
        pulse_done();
        vectors++; if ({busy, start, turn} !== 5'b10001) begin
            miscompares++; $display("FAIL done1_follow: got %b expected 10001", {busy, start, turn}); end
        // Still sitting on node 1: must not retrigger until the sensors leave it.
        tick(20);
        vectors++; if (start !== 1'b0 || node_count !== 5'd1) begin
            miscompares++; $display("FAIL rearm_hold: start %b node %0d expected 0 node 1", start, node_count); end
        approach_node(4);
        vectors++; if ({start, turn} !== 4'b1011 || node_count !== 5'd2) begin
            miscompares++; $display("FAIL node2_turn: got start/turn %b node %0d expected 1011 node 2", {start, turn}, node_count); end
        pulse_done();
        approach_node(4);
        vectors++; if ({start, turn} !== 4'b1100) begin
            miscompares++; $display("FAIL node3_turn: got %b expected 1100", {start, turn}); end
        pulse_done();
        vectors++; if ({finished, busy, start, turn} !== 6'b100000 || node_count !== 5'd3) begin
            miscompares++; $display("FAIL list_end: got %b node %0d expected 100000 node 3", {finished, busy, start, turn}, node_count); end
        pulse_go();
        vectors++; if ({busy, finished, turn} !== 5'b10001 || node_count !== 5'd0) begin
            miscompares++; $display("FAIL replay_entry: got %b node %0d expected 10001 node 0", {busy, finished, turn}, node_count); end
        approach_node(4);
        vectors++; if ({start, turn} !== 4'b1010) begin
            miscompares++; $display("FAIL replay_turn: got %b expected 1010", {start, turn}); end
    endtask

    task automatic test_debounce();
        do_reset();
        write_code(3'b010);
        pulse_go();
        set_sens(3'b010); tick(2);
        set_sens(3'b111); tick(3);
        set_sens(3'b010); tick(1);
        set_sens(3'b111); tick(3);
        vectors++; if (start !== 1'b0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL deb_broken: start/busy %b%b expected 01", start, busy); end
        tick(1);
        vectors++; if ({start, turn} !== 4'b1010) begin
            miscompares++; $display("FAIL deb_fourth: got %b expected 1010", {start, turn}); end
    endtask

    task automatic test_stop_code();
        int seen_start;
        do_reset();
        write_code(3'b011); write_code(3'b000);
        pulse_go();
        approach_node(4);
        vectors++; if ({start, turn} !== 4'b1011) begin
            miscompares++; $display("FAIL stop_node1: got %b expected 1011", {start, turn}); end
        pulse_done();
        seen_start = 0;
        set_sens(3'b010); tick(1);
        set_sens(3'b111);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (start === 1'b1) seen_start++;
        end
        vectors++; if (seen_start != 0) begin
            miscompares++; $display("FAIL stop_no_start: start seen %0d cycles expected 0", seen_start); end
        vectors++; if ({finished, busy} !== 2'b10 || node_count !== 5'd2) begin
            miscompares++; $display("FAIL stop_finished: got %b node %0d expected 10 node 2", {finished, busy}, node_count); end
    endtask

    task automatic test_timeout();
        do_reset();
        write_code(3'b010);
        pulse_go();
        approach_node(4);
        tick(99);
        vectors++; if ({error, start} !== 2'b01) begin
            miscompares++; $display("FAIL tmo_early: error/start %b expected 01", {error, start}); end
        tick(1);
        vectors++; if ({error, start, busy, turn} !== 6'b100000) begin
            miscompares++; $display("FAIL tmo_error: got %b expected 100000", {error, start, busy, turn}); end
        pulse_go();
        pulse_done();
        vectors++; if ({error, busy} !== 2'b10) begin
            miscompares++; $display("FAIL tmo_sticky: got %b expected 10", {error, busy}); end
        pulse_clr();
        vectors++; if ({error, busy, finished} !== 3'b000 || cmd_count !== 5'd0) begin
            miscompares++; $display("FAIL tmo_clear: got %b count %0d expected 000 count 0", {error, busy, finished}, cmd_count); end
        // done arriving on the last allowed cycle beats the timeout.
        write_code(3'b011);
        pulse_go();
        approach_node(4);
        tick(99);
        pulse_done();
        vectors++; if ({error, finished} !== 2'b01) begin
            miscompares++; $display("FAIL tmo_done_wins: error/finished %b expected 01", {error, finished}); end
    endtask

    task automatic test_store_limits();
        do_reset();
        write_code(3'b110);
        write_code(3'b111);
        vectors++; if (cmd_count !== 5'd0) begin
            miscompares++; $display("FAIL invalid_code: count %0d expected 0", cmd_count); end
        for (int i = 0; i < 15; i++) write_code(3'(i % 5));
        vectors++; if (cmd_full !== 1'b0 || cmd_count !== 5'd15) begin
            miscompares++; $display("FAIL almost_full: full %b count %0d expected 0 15", cmd_full, cmd_count); end
        write_code(3'b001);
        write_code(3'b010);
        vectors++; if (cmd_full !== 1'b1 || cmd_count !== 5'd16) begin
            miscompares++; $display("FAIL full: full %b count %0d expected 1 16", cmd_full, cmd_count); end
        // Writes during a run are dropped; reset mid-run aborts and empties the list.
        pulse_clr();
        write_code(3'b010);
        pulse_go();
        write_code(3'b011);
        vectors++; if (cmd_count !== 5'd1 || busy !== 1'b1) begin
            miscompares++; $display("FAIL run_write: count %0d busy %b expected 1 1", cmd_count, busy); end
        rst = 1'b1; tick(1); rst = 1'b0;
        vectors++; if (busy !== 1'b0 || cmd_count !== 5'd0) begin
            miscompares++; $display("FAIL midrun_reset: busy %b count %0d expected 0 0", busy, cmd_count); end
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_debounce();
        test_stop_code();
        test_timeout();
        test_store_limits();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
